// File: rtl/console_port_sequencer.sv
// console_port_sequencer
// Drives one (S)NES controller-port data line from the system clock domain.
// Console latch/clock pins are synchronised, edge-detected and used to load
// a frame from the frame buffer and shift it out MSB first. Once the frame is
// exhausted the line is filled with OVERREAD_VAL. Lag frames (a latch that
// finds no new frame) and overreads are reported.
module console_port_sequencer #(
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter logic        OVERREAD_VAL = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             con_latch,
   input  logic             con_clk,
   input  logic [WIDTH-1:0] frame_data,
   input  logic             frame_valid,
   output logic             frame_ready,
   output logic             con_data,
   output logic             busy,
   output logic             overread_flag,
   output logic [6:0]       bit_count,
   output logic [15:0]      lag_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LATCHED  = 2'd1,
      SHIFTING = 2'd2,
      DRAINED  = 2'd3
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] latch_sync;
   logic [SYNC_STAGES-1:0] clk_sync;
   logic                   latch_s;
   logic                   clk_s;
   logic                   latch_d;
   logic                   clk_d;
   logic                   latch_rise;
   logic                   clk_rise;
   logic [WIDTH-1:0]       sr;
   logic [WIDTH-1:0]       held_frame;

   assign latch_s    = latch_sync[SYNC_STAGES-1];
   assign clk_s      = clk_sync[SYNC_STAGES-1];
   assign latch_rise = latch_s & ~latch_d;
   assign clk_rise   = clk_s & ~clk_d;

   // Handshake coincides with the load edge so valid && ready marks exactly
   // the frame captured; it is decoded from registers only, so it is glitch-free.
   assign frame_ready = latch_rise;

   // Pin synchronisers and edge history
   always_ff @(posedge clk) begin
      if (rst) begin
         latch_sync <= '0;
         clk_sync   <= '0;
         latch_d    <= 1'b0;
         clk_d      <= 1'b0;
      end else begin
         latch_sync <= {latch_sync[SYNC_STAGES-2:0], con_latch};
         clk_sync   <= {clk_sync[SYNC_STAGES-2:0], con_clk};
         latch_d    <= latch_s;
         clk_d      <= clk_s;
      end
   end

   // Port FSM: load on latch rise (takes priority over a coincident clock edge),
   // shift on clock rise, report overread once the frame is drained
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         sr            <= '1;
         held_frame    <= '1;
         con_data      <= 1'b1;
         busy          <= 1'b0;
         overread_flag <= 1'b0;
         bit_count     <= '0;
         lag_count     <= '0;
      end else begin
         con_data <= sr[WIDTH-1];
         if (latch_rise) begin
            if (frame_valid) begin
               sr         <= frame_data;
               held_frame <= frame_data;
            end else begin
               sr <= held_frame;
               if (lag_count != 16'hFFFF) lag_count <= lag_count + 16'd1;
            end
            bit_count     <= '0;
            overread_flag <= 1'b0;
            busy          <= 1'b1;
            state         <= LATCHED;
         end else begin
            case (state)
               LATCHED: begin
                  if (!latch_s) state <= SHIFTING;
               end
               SHIFTING: begin
                  if (clk_rise) begin
                     sr        <= {sr[WIDTH-2:0], OVERREAD_VAL};
                     bit_count <= bit_count + 7'd1;
                     if (bit_count == 7'(WIDTH - 1)) begin
                        state <= DRAINED;
                        busy  <= 1'b0;
                     end
                  end
               end
               DRAINED: begin
                  if (clk_rise) begin
                     sr            <= {sr[WIDTH-2:0], OVERREAD_VAL};
                     overread_flag <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_console_port_sequencer.sv
// tb_console_port_sequencer
// Directed table-driven bench for console_port_sequencer (WIDTH=16).
module tb_console_port_sequencer;

   localparam int HOLD = 6;   // cycles per console pin phase

   logic        clk = 1'b0;
   logic        rst;
   logic        con_latch;
   logic        con_clk;
   logic [15:0] frame_data;
   logic        frame_valid;
   logic        frame_ready;
   logic        con_data;
   logic        busy;
   logic        overread_flag;
   logic [6:0]  bit_count;
   logic [15:0] lag_count;

   console_port_sequencer #(
      .WIDTH(16),
      .SYNC_STAGES(2),
      .OVERREAD_VAL(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .con_latch(con_latch),
      .con_clk(con_clk),
      .frame_data(frame_data),
      .frame_valid(frame_valid),
      .frame_ready(frame_ready),
      .con_data(con_data),
      .busy(busy),
      .overread_flag(overread_flag),
      .bit_count(bit_count),
      .lag_count(lag_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int consumed = 0;
   int rdy_cyc  = 0;

   // Count consumed frames and ready-high cycles, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst && frame_ready) begin
         rdy_cyc++;
         if (frame_valid) consumed++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clk_pulse();
      con_clk = 1'b1; cyc(HOLD);
      con_clk = 1'b0; cyc(HOLD);
   endtask

   typedef struct {
      bit          do_latch;
      logic [15:0] frame;
      bit          valid;
      int          nclk;
      logic [15:0] exp_frame;
      int          exp_bits;
      bit          exp_ovr;
      bit          exp_busy;
      int          exp_lag;
      int          exp_cons;
      int          exp_rdy;
   } vec_t;

   vec_t vecs[5];
   int   pos;
   logic exp_bit;

   initial begin
      vecs[0] = '{1'b1, 16'h7FFE, 1'b1, 16, 16'h7FFE, 16, 1'b0, 1'b0, 0, 1, 1};
      vecs[1] = '{1'b0, 16'h0000, 1'b0,  3, 16'h7FFE, 16, 1'b1, 1'b0, 0, 1, 1};
      vecs[2] = '{1'b1, 16'h0000, 1'b0, 16, 16'h7FFE, 16, 1'b0, 1'b0, 1, 1, 2};
      vecs[3] = '{1'b1, 16'h00FF, 1'b1,  5, 16'h00FF,  5, 1'b0, 1'b1, 1, 2, 3};
      vecs[4] = '{1'b1, 16'hA5A5, 1'b1, 16, 16'hA5A5, 16, 1'b0, 1'b0, 1, 3, 4};

      rst = 1'b1; con_latch = 1'b0; con_clk = 1'b0;
      frame_data = 16'h0000; frame_valid = 1'b0;
      cyc(5);
      chk("rst_con_data", 32'(con_data), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(frame_ready), 32'd0);
      chk("rst_ovr", 32'(overread_flag), 32'd0);
      chk("rst_bits", 32'(bit_count), 32'd0);
      chk("rst_lag", 32'(lag_count), 32'd0);
      rst = 1'b0;
      cyc(2);

      pos = 0;
      foreach (vecs[v]) begin
         if (vecs[v].do_latch) begin
            frame_data  = vecs[v].frame;
            frame_valid = vecs[v].valid;
            con_latch = 1'b1; cyc(HOLD);
            chk($sformatf("v%0d_latch_data", v), 32'(con_data), 32'(vecs[v].exp_frame[15]));
            chk($sformatf("v%0d_latch_bits", v), 32'(bit_count), 32'd0);
            chk($sformatf("v%0d_latch_ovr", v), 32'(overread_flag), 32'd0);
            chk($sformatf("v%0d_latch_busy", v), 32'(busy), 32'd1);
            con_latch = 1'b0; cyc(HOLD);
            frame_valid = 1'b0;
            pos = 0;
         end
         for (int i = 0; i < vecs[v].nclk; i++) begin
            clk_pulse();
            pos++;
            exp_bit = (pos < 16) ? vecs[v].exp_frame[15-pos] : 1'b1;
            chk($sformatf("v%0d_clk%0d_data", v, i), 32'(con_data), 32'(exp_bit));
            chk($sformatf("v%0d_clk%0d_busy", v, i), 32'(busy), 32'(pos < 16));
         end
         chk($sformatf("v%0d_bits", v), 32'(bit_count), 32'(vecs[v].exp_bits));
         chk($sformatf("v%0d_ovr", v), 32'(overread_flag), 32'(vecs[v].exp_ovr));
         chk($sformatf("v%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
         chk($sformatf("v%0d_lag", v), 32'(lag_count), 32'(vecs[v].exp_lag));
         chk($sformatf("v%0d_consumed", v), 32'(consumed), 32'(vecs[v].exp_cons));
         chk($sformatf("v%0d_ready_cycles", v), 32'(rdy_cyc), 32'(vecs[v].exp_rdy));
      end

      // Coincident latch and clock rise: load wins, clock edge dropped
      frame_data = 16'hF0F0; frame_valid = 1'b1;
      con_latch = 1'b1; cyc(HOLD);
      con_latch = 1'b0; cyc(HOLD);
      clk_pulse(); clk_pulse();
      chk("coll_pre_bits", 32'(bit_count), 32'd2);
      frame_data = 16'h3C3C;
      con_latch = 1'b1; con_clk = 1'b1; cyc(HOLD);
      chk("coll_bits", 32'(bit_count), 32'd0);
      chk("coll_data", 32'(con_data), 32'd0);
      chk("coll_consumed", 32'(consumed), 32'd5);
      con_latch = 1'b0; con_clk = 1'b0; cyc(HOLD);
      frame_valid = 1'b0;
      clk_pulse();
      chk("coll_clk1_bits", 32'(bit_count), 32'd1);
      clk_pulse();
      chk("coll_clk2_data", 32'(con_data), 32'd1);

      // Reset mid-frame after 8 bits of 16'h1234
      frame_data = 16'h1234; frame_valid = 1'b1;
      con_latch = 1'b1; cyc(HOLD);
      con_latch = 1'b0; cyc(HOLD);
      frame_valid = 1'b0;
      for (int i = 0; i < 8; i++) clk_pulse();
      chk("pre_rst_data", 32'(con_data), 32'd0);
      chk("pre_rst_bits", 32'(bit_count), 32'd8);
      rst = 1'b1; cyc(1);
      chk("mid_rst_data", 32'(con_data), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_lag", 32'(lag_count), 32'd0);
      chk("mid_rst_bits", 32'(bit_count), 32'd0);
      rst = 1'b0; cyc(2);
      for (int i = 0; i < 3; i++) clk_pulse();
      chk("post_rst_bits", 32'(bit_count), 32'd0);
      chk("post_rst_data", 32'(con_data), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_ovr", 32'(overread_flag), 32'd0);
      // Lag latch after reset replays the cleared (all-ones) held frame
      con_latch = 1'b1; cyc(HOLD);
      con_latch = 1'b0; cyc(HOLD);
      chk("post_rst_lag", 32'(lag_count), 32'd1);
      chk("post_rst_replay0", 32'(con_data), 32'd1);
      clk_pulse();
      chk("post_rst_replay1", 32'(con_data), 32'd1);
      chk("post_rst_consumed", 32'(consumed), 32'd6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
